// File: rtl/tbox_lookup_pipe_pkg.sv
// AES T-table support package: S-box constants, GF(2^8) helpers and Te0/Td0 word builders.
package aes_tbox_pkg;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Multiply by x modulo the AES polynomial 0x11B.
  function automatic logic [7:0] gf_xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // GF(2^8) product built from repeated xtime.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = 8'h00;
    pw  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[3'(i)]) acc = acc ^ pw;
      pw = gf_xtime(pw);
    end
    return acc;
  endfunction

  // Te0 word from the forward S-box output.
  function automatic logic [31:0] te0_word(input logic [7:0] s);
    return {gf_mul(s, 8'h02), s, s, gf_mul(s, 8'h03)};
  endfunction

  // Td0 word from the inverse S-box output.
  function automatic logic [31:0] td0_word(input logic [7:0] si);
    return {gf_mul(si, 8'h0e), gf_mul(si, 8'h09), gf_mul(si, 8'h0d), gf_mul(si, 8'h0b)};
  endfunction

  // Rotate right by 8*rot bits, turning T0 into T1..T3.
  function automatic logic [31:0] rotr_bytes(input logic [31:0] w, input logic [1:0] rot);
    logic [31:0] r;
    case (rot)
      2'd0:    r = w;
      2'd1:    r = {w[7:0],  w[31:8]};
      2'd2:    r = {w[15:0], w[31:16]};
      default: r = {w[23:0], w[31:24]};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/tbox_lookup_pipe_if.sv
// Request/response bus of the T-table lookup engine.
interface tbox_lookup_pipe_if #(
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic                  in_dec;
  logic                  in_last;
  logic [8*LANES-1:0]    in_addr;
  logic [2*LANES-1:0]    in_rot;
  logic [TAG_W-1:0]      in_tag;
  logic                  out_valid;
  logic                  out_ready;
  logic [32*LANES-1:0]   out_data;
  logic [TAG_W-1:0]      out_tag;

  modport master (
    output in_valid, in_dec, in_last, in_addr, in_rot, in_tag, out_ready,
    input  in_ready, out_valid, out_data, out_tag
  );

  modport slave (
    input  in_valid, in_dec, in_last, in_addr, in_rot, in_tag, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/tbox_lookup_pipe_lane.sv
// One T-table lane: registered read of Te/Td word with byte rotation.
// Last-round byte output exists only when TBOX_LASTRND_EN is defined.
module tbox_lane
  import aes_tbox_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        en_i,
  input  logic        dec_i,
`ifdef TBOX_LASTRND_EN
  input  logic        last_i,
`endif
  input  logic [1:0]  rot_i,
  input  logic [7:0]  addr_i,
  output logic [31:0] word_o
);

  logic [7:0]  sbyte;
  logic [31:0] base;
  logic [31:0] word_d;
  logic [31:0] word_q;

  // Table lookup and rotation; the word holds when the stage is not enabled.
  always_comb begin
    sbyte = SBOX[addr_i];
    base  = te0_word(sbyte);
    case (dec_i)
      MODE_ENC: begin
        sbyte = SBOX[addr_i];
        base  = te0_word(sbyte);
      end
      MODE_DEC: begin
        sbyte = INV_SBOX[addr_i];
        base  = td0_word(sbyte);
      end
    endcase
`ifdef TBOX_LASTRND_EN
    if (last_i) base = {24'h0, sbyte};
`endif
    word_d = en_i ? rotr_bytes(base, rot_i) : word_q;
  end

  // Output word register.
  always_ff @(posedge clk) begin
    if (reset) word_q <= '0;
    else       word_q <= word_d;
  end

  assign word_o = word_q;

endmodule

// File: rtl/tbox_lookup_pipe.sv
// Multi-lane AES T-table lookup, 2-stage valid/ready pipeline with tag passthrough.
// Optional last-round byte mode: define TBOX_LASTRND_EN.
module tbox_lookup_pipe
  import aes_tbox_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned TAG_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  tbox_lookup_pipe_if.slave  bus
);

  localparam int unsigned ADDR_W = 8 * LANES;
  localparam int unsigned ROT_W  = 2 * LANES;
  localparam int unsigned DATA_W = 32 * LANES;

  logic              en1;
  logic              en2;
  logic              accept;
  logic              lane_en;
  logic              v1_d, v1_q;
  logic              v2_d, v2_q;
  logic              dec_d, dec_q;
  logic [ADDR_W-1:0] addr_d, addr_q;
  logic [ROT_W-1:0]  rot_d, rot_q;
  logic [TAG_W-1:0]  tag1_d, tag1_q;
  logic [TAG_W-1:0]  tag2_d, tag2_q;
  logic [DATA_W-1:0] lane_data;
`ifdef TBOX_LASTRND_EN
  logic              last_d, last_q;
`else
  logic              unused_last;
  assign unused_last = bus.in_last;
`endif

  // Stage enables: a stage advances when it is empty or its successor advances.
  always_comb begin
    en2     = !v2_q || bus.out_ready;
    en1     = !v1_q || en2;
    accept  = bus.in_valid && en1;
    lane_en = en2 && v1_q;
  end

  // Next-state for valid bits, S1 capture and S2 tag.
  always_comb begin
    v1_d   = v1_q;
    v2_d   = v2_q;
    dec_d  = dec_q;
    addr_d = addr_q;
    rot_d  = rot_q;
    tag1_d = tag1_q;
    tag2_d = tag2_q;
`ifdef TBOX_LASTRND_EN
    last_d = last_q;
`endif
    if (en1) v1_d = bus.in_valid;
    if (accept) begin
      dec_d  = bus.in_dec;
      addr_d = bus.in_addr;
      rot_d  = bus.in_rot;
      tag1_d = bus.in_tag;
`ifdef TBOX_LASTRND_EN
      last_d = bus.in_last;
`endif
    end
    if (en2) v2_d = v1_q;
    if (lane_en) tag2_d = tag1_q;
  end

  // Pipeline control and sideband registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      dec_q  <= 1'b0;
      addr_q <= '0;
      rot_q  <= '0;
      tag1_q <= '0;
      tag2_q <= '0;
`ifdef TBOX_LASTRND_EN
      last_q <= 1'b0;
`endif
    end else begin
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      dec_q  <= dec_d;
      addr_q <= addr_d;
      rot_q  <= rot_d;
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
`ifdef TBOX_LASTRND_EN
      last_q <= last_d;
`endif
    end
  end

  // S2 table read, one lane per index byte.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tbox_lane u_lane (
      .clk    (clk),
      .reset  (reset),
      .en_i   (lane_en),
      .dec_i  (dec_q),
`ifdef TBOX_LASTRND_EN
      .last_i (last_q),
`endif
      .rot_i  (rot_q[2*i +: 2]),
      .addr_i (addr_q[8*i +: 8]),
      .word_o (lane_data[32*i +: 32])
    );
  end

  assign bus.in_ready  = en1;
  assign bus.out_valid = v2_q;
  assign bus.out_data  = lane_data;
  assign bus.out_tag   = tag2_q;

endmodule
